// File: rtl/mio_clk_gate_ctrl.sv
// Clock-gate controller for a gated clock domain shared by NUM_REQ requesters.
// Wakes the gate, acks requesters once the clock is stable, and gates off after an idle window.
module mio_clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic [NUM_REQ-1:0] ack,
    output logic               clk_en,
    output logic [1:0]         state
);

    localparam int MAX_CNT = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             any;

    assign any = (|req) | force_on;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (any) begin
                    state_next = ST_WAKE;
                    cnt_next   = WAKE_LOAD;
                end
            end
            // A request dropped during wake-up does not abort it; ON falls to IDLE afterwards.
            ST_WAKE: begin
                if (cnt_q == '0) state_next = ST_ON;
                else             cnt_next   = cnt_q - CNT_ONE;
            end
            ST_ON: begin
                if (!any) begin
                    state_next = ST_IDLE;
                    cnt_next   = IDLE_LOAD;
                end
            end
            ST_IDLE: begin
                if (any)               state_next = ST_ON;
                else if (cnt_q == '0)  state_next = ST_OFF;
                else                   cnt_next   = cnt_q - CNT_ONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            clk_en  <= 1'b0;
            ack     <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            clk_en  <= (state_next != ST_OFF);
            // force_on keeps the FSM awake but is not a requester, so it is never acked.
            ack     <= req & {NUM_REQ{state_next == ST_ON}};
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mio_clk_gate_ctrl.sv
// Scoreboard bench for mio_clk_gate_ctrl: each step drives inputs, queues the expected
// outputs, and the same task pops and compares them once the DUT has responded.
module tb_mio_clk_gate_ctrl;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ack;
    logic       clk_en;
    logic [1:0] state;

    typedef struct {
        string      name;
        bit         clk_step;
        logic       rst;
        logic [3:0] req;
        logic       frc;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
    } step_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
    } exp_t;

    step_t plan[$];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    mio_clk_gate_ctrl #(
        .NUM_REQ    (4),
        .WAKE_CYCLES(2),
        .IDLE_CYCLES(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .force_on(force_on),
        .ack     (ack),
        .clk_en  (clk_en),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Appends reps identical steps; clk_step=0 means sample without a clock edge.
    task automatic add(input string n, input bit ce, input logic r, input logic [3:0] q,
                       input logic f, input logic [1:0] st, input logic en,
                       input logic [3:0] a, input int reps = 1);
        for (int i = 0; i < reps; i++) plan.push_back('{n, ce, r, q, f, st, en, a});
    endtask

    task automatic test_reset();
        step_t s;
        exp_t  e;
        add("reset_hold",    1, 1'b0, 4'hF, 1'b0, S_OFF, 1'b0, 4'h0, 4);
        add("reset_release", 1, 1'b1, 4'h0, 1'b0, S_OFF, 1'b0, 4'h0, 2);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    task automatic test_wake();
        step_t s;
        exp_t  e;
        add("wake_edge0", 1, 1'b1, 4'h1, 1'b0, S_WAKE, 1'b1, 4'h0);
        add("wake_edge1", 1, 1'b1, 4'h1, 1'b0, S_WAKE, 1'b1, 4'h0);
        add("wake_on",    1, 1'b1, 4'h1, 1'b0, S_ON,   1'b1, 4'h1, 2);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    // Release to gate-off takes 17 edges: one into IDLE, then 16 in IDLE.
    task automatic test_idle();
        step_t s;
        exp_t  e;
        add("idle_hold", 1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 16);
        add("idle_off",  1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0, 2);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    task automatic test_rerequest();
        step_t s;
        exp_t  e;
        add("rereq_wake",   1, 1'b1, 4'h4, 1'b0, S_WAKE, 1'b1, 4'h0, 2);
        add("rereq_on",     1, 1'b1, 4'h4, 1'b0, S_ON,   1'b1, 4'h4);
        add("rereq_idle",   1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 16);
        add("rereq_cnt0",   1, 1'b1, 4'h4, 1'b0, S_ON,   1'b1, 4'h4);
        add("rereq_stay",   1, 1'b1, 4'h4, 1'b0, S_ON,   1'b1, 4'h4);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    task automatic test_multi_force();
        step_t s;
        exp_t  e;
        add("multi_ack",      1, 1'b1, 4'h5, 1'b0, S_ON,   1'b1, 4'h5);
        add("multi_drop_one", 1, 1'b1, 4'h4, 1'b0, S_ON,   1'b1, 4'h4);
        add("force_hold_on",  1, 1'b1, 4'h0, 1'b1, S_ON,   1'b1, 4'h0, 3);
        add("force_rel_idle", 1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 16);
        add("force_rel_off",  1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("force_wake",     1, 1'b1, 4'h0, 1'b1, S_WAKE, 1'b1, 4'h0, 2);
        add("force_on_noack", 1, 1'b1, 4'h0, 1'b1, S_ON,   1'b1, 4'h0, 2);
        add("force_req_ack",  1, 1'b1, 4'h5, 1'b1, S_ON,   1'b1, 4'h5);
        add("force_req_drop", 1, 1'b1, 4'h0, 1'b1, S_ON,   1'b1, 4'h0);
        add("force_end_idle", 1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 16);
        add("force_end_off",  1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    // Cancel during wake still completes the wake, then falls straight to IDLE.
    task automatic test_back_to_back();
        step_t s;
        exp_t  e;
        add("cancel_wake0", 1, 1'b1, 4'h1, 1'b0, S_WAKE, 1'b1, 4'h0);
        add("cancel_wake1", 1, 1'b1, 4'h0, 1'b0, S_WAKE, 1'b1, 4'h0);
        add("cancel_on",    1, 1'b1, 4'h0, 1'b0, S_ON,   1'b1, 4'h0);
        add("cancel_idle",  1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0);
        add("idle_req_ack", 1, 1'b1, 4'h2, 1'b0, S_ON,   1'b1, 4'h2);
        add("b2b_idle",     1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 16);
        add("b2b_off",      1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    // Non-edge steps assert reset between clock edges and sample before the next edge.
    task automatic test_async_reset();
        step_t s;
        exp_t  e;
        add("ar_wake",       1, 1'b1, 4'h1, 1'b0, S_WAKE, 1'b1, 4'h0);
        add("ar_mid_wake",   0, 1'b0, 4'h1, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_rel_wake",   0, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_after_wake", 1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_wake2",      1, 1'b1, 4'h8, 1'b0, S_WAKE, 1'b1, 4'h0, 2);
        add("ar_on",         1, 1'b1, 4'h8, 1'b0, S_ON,   1'b1, 4'h8);
        add("ar_mid_on",     0, 1'b0, 4'h8, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_rel_on",     0, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_after_on",   1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_wake3",      1, 1'b1, 4'h8, 1'b0, S_WAKE, 1'b1, 4'h0, 2);
        add("ar_on3",        1, 1'b1, 4'h8, 1'b0, S_ON,   1'b1, 4'h8);
        add("ar_idle",       1, 1'b1, 4'h0, 1'b0, S_IDLE, 1'b1, 4'h0, 5);
        add("ar_mid_idle",   0, 1'b0, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_rel_idle",   0, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0);
        add("ar_after_idle", 1, 1'b1, 4'h0, 1'b0, S_OFF,  1'b0, 4'h0, 2);
        while (plan.size() > 0) begin
            s = plan.pop_front();
            reset_n = s.rst; req = s.req; force_on = s.frc;
            sb.push_back('{s.name, s.st, s.en, s.ack});
            if (s.clk_step) begin @(posedge clk); #1; end else #1;
            e = sb.pop_front();
            n_cmp++;
            if ({state, clk_en, ack} !== {e.st, e.en, e.ack}) begin
                n_err++;
                $display("FAIL %s: got state=%0d clk_en=%b ack=%b, want state=%0d clk_en=%b ack=%b",
                         e.name, state, clk_en, ack, e.st, e.en, e.ack);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 4'h0;
        force_on = 1'b0;
        #2;
        test_reset();
        test_wake();
        test_idle();
        test_rerequest();
        test_multi_force();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
